plru_set_tracker: RTL and testbench

//  Multi-set tree-PLRU replacement tracker for set-associative caches/TLBs: holds one
//  (NUM_WAYS-1)-bit PLRU tree per set, updates it on access ("touch") and returns a

---
 rtl/plru_set_tracker.sv | 183 ++++++++++++++++++
 tb/tb_plru_set_tracker.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plru_set_tracker.sv
// Multi-set tree-PLRU replacement tracker with invalid-first allocation, way locking,
// registered victim lookup and a sequenced flush. Optional macro: PLRU_TOUCH_BYPASS_EN.
module plru_set_tracker #(
    parameter int NUM_WAYS = 8,
    parameter int NUM_SETS = 64,
    localparam int WayW = $clog2(NUM_WAYS),
    localparam int SetW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    output logic                busy_o,
    input  logic                touch_valid_i,
    input  logic [SetW-1:0]     touch_set_i,
    input  logic [WayW-1:0]     touch_way_i,
    input  logic                victim_req_i,
    output logic                victim_ready_o,
    input  logic [SetW-1:0]     victim_set_i,
    input  logic [NUM_WAYS-1:0] way_valid_i,
    input  logic [NUM_WAYS-1:0] way_lock_i,
    output logic                victim_valid_o,
    output logic [WayW-1:0]     victim_way_o,
    output logic [NUM_WAYS-1:0] victim_oh_o,
    output logic                victim_none_o
);

    localparam int NodeN = NUM_WAYS - 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                state_reg;
    logic                  busy_reg;
    logic [SetW-1:0]       flush_cnt_reg;
    logic [NodeN-1:0]      tree_reg [NUM_SETS];

    logic                  victim_valid_reg;
    logic [WayW-1:0]       victim_way_reg;
    logic [NUM_WAYS-1:0]   victim_oh_reg;
    logic                  victim_none_reg;

    logic [NodeN-1:0]      touch_cur_tree;
    logic [NodeN-1:0]      touched_tree;
    logic [NodeN-1:0]      lookup_tree;
    logic [NodeN-1:0]      lo_locked;
    logic [NodeN-1:0]      hi_locked;
    logic [NodeN-1:0]      go_hi;
    logic [NUM_WAYS-1:0]   walk_oh;
    logic [NUM_WAYS-1:0]   free_ways;
    logic [NUM_WAYS-1:0]   free_oh;
    logic [NUM_WAYS-1:0]   sel_oh;
    logic [WayW-1:0]       sel_way;
    logic                  all_locked;
    logic                  accept;

    assign victim_ready_o = (state_reg == ST_IDLE) && !flush_i;
    assign accept         = victim_req_i && victim_ready_o;
    assign busy_o         = busy_reg;

    assign touch_cur_tree = tree_reg[touch_set_i];

`ifdef PLRU_TOUCH_BYPASS_EN
    // Same-set touch in the request cycle is forwarded so the lookup sees the fresh tree.
    assign lookup_tree = (touch_valid_i && (touch_set_i == victim_set_i) && (state_reg == ST_IDLE))
                         ? touched_tree : tree_reg[victim_set_i];
`else
    assign lookup_tree = tree_reg[victim_set_i];
`endif

    // Per-node logic: node at (level gi, position gj) covers ways [gj*Span, (gj+1)*Span).
    for (genvar gi = 0; gi < WayW; gi++) begin : g_lvl
        localparam int Span = NUM_WAYS >> gi;
        for (genvar gj = 0; gj < (1 << gi); gj++) begin : g_node
            localparam int Node = (1 << gi) - 1 + gj;
            logic on_path;

            assign lo_locked[Node] = &way_lock_i[gj*Span +: Span/2];
            assign hi_locked[Node] = &way_lock_i[gj*Span + Span/2 +: Span/2];
            assign on_path = ((touch_way_i >> (WayW - gi)) == WayW'(gj));
            assign touched_tree[Node] = on_path ? ~touch_way_i[WayW-1-gi] : touch_cur_tree[Node];
            // Steer away from a fully locked subtree; the walk only needs this resolved bit.
            assign go_hi[Node] = lookup_tree[Node] ? !hi_locked[Node] : lo_locked[Node];
        end
    end

    // A way is the walk result when every ancestor steers towards it.
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        logic [WayW-1:0] path_match;
        for (genvar gj = 0; gj < WayW; gj++) begin : g_anc
            localparam int Node = (1 << gj) - 1 + (gi >> (WayW - gj));
            localparam logic Dir = 1'((gi >> (WayW - 1 - gj)) & 1);
            assign path_match[gj] = (go_hi[Node] == Dir);
        end
        assign walk_oh[gi] = &path_match;
    end

    assign free_ways  = ~way_valid_i & ~way_lock_i;
    assign free_oh    = free_ways & (~free_ways + NUM_WAYS'(1));
    assign all_locked = &way_lock_i;

    always_comb begin
        sel_oh = '0;
        if (|free_ways) begin
            sel_oh = free_oh;
        end else if (!all_locked) begin
            sel_oh = walk_oh;
        end
    end

    always_comb begin
        sel_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (sel_oh[i]) begin
                sel_way = sel_way | WayW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            flush_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (flush_i) begin
                        state_reg     <= ST_FLUSH;
                        busy_reg      <= 1'b1;
                        flush_cnt_reg <= '0;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt_reg <= flush_cnt_reg + 1'b1;
                    if (flush_cnt_reg == SetW'(NUM_SETS - 1)) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                tree_reg[i] <= '0;
            end
        end else if (state_reg == ST_FLUSH) begin
            tree_reg[flush_cnt_reg] <= '0;
        end else if (touch_valid_i) begin
            tree_reg[touch_set_i] <= touched_tree;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            victim_valid_reg <= 1'b0;
            victim_way_reg   <= '0;
            victim_oh_reg    <= '0;
            victim_none_reg  <= 1'b0;
        end else begin
            victim_valid_reg <= accept;
            if (accept) begin
                victim_way_reg  <= sel_way;
                victim_oh_reg   <= sel_oh;
                victim_none_reg <= (sel_oh == '0);
            end
        end
    end

    assign victim_valid_o = victim_valid_reg;
    assign victim_way_o   = victim_way_reg;
    assign victim_oh_o    = victim_oh_reg;
    assign victim_none_o  = victim_none_reg;

endmodule

// File: tb/tb_plru_set_tracker.sv
// Directed bench for plru_set_tracker (8 ways, 64 sets); honours PLRU_TOUCH_BYPASS_EN.
module tb_plru_set_tracker;

    localparam int NUM_WAYS = 8;
    localparam int NUM_SETS = 64;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       busy_o;
    logic       touch_valid_i;
    logic [5:0] touch_set_i;
    logic [2:0] touch_way_i;
    logic       victim_req_i;
    logic       victim_ready_o;
    logic [5:0] victim_set_i;
    logic [7:0] way_valid_i;
    logic [7:0] way_lock_i;
    logic       victim_valid_o;
    logic [2:0] victim_way_o;
    logic [7:0] victim_oh_o;
    logic       victim_none_o;

    int checks = 0;
    int errors = 0;

    plru_set_tracker #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .touch_valid_i  (touch_valid_i),
        .touch_set_i    (touch_set_i),
        .touch_way_i    (touch_way_i),
        .victim_req_i   (victim_req_i),
        .victim_ready_o (victim_ready_o),
        .victim_set_i   (victim_set_i),
        .way_valid_i    (way_valid_i),
        .way_lock_i     (way_lock_i),
        .victim_valid_o (victim_valid_o),
        .victim_way_o   (victim_way_o),
        .victim_oh_o    (victim_oh_o),
        .victim_none_o  (victim_none_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic request(input logic [5:0] set, input logic [7:0] valid, input logic [7:0] lock);
        victim_req_i = 1'b1;
        victim_set_i = set;
        way_valid_i  = valid;
        way_lock_i   = lock;
        tick();
        victim_req_i = 1'b0;
        way_lock_i   = 8'h00;
        way_valid_i  = 8'hFF;
    endtask

    task automatic touch(input logic [5:0] set, input logic [2:0] way);
        touch_valid_i = 1'b1;
        touch_set_i   = set;
        touch_way_i   = way;
        tick();
        touch_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        flush_i = 1'b0; touch_valid_i = 1'b0; touch_set_i = '0; touch_way_i = '0;
        victim_req_i = 1'b0; victim_set_i = '0; way_valid_i = 8'hFF; way_lock_i = 8'h00;
        #2;
        checks++;
        if (busy_o !== 1'b0 || victim_valid_o !== 1'b0 || victim_way_o !== 3'd0 ||
            victim_oh_o !== 8'h00 || victim_none_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b valid=%b way=%0d oh=%h none=%b, required all 0",
                     busy_o, victim_valid_o, victim_way_o, victim_oh_o, victim_none_o);
        end
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        checks++;
        if (victim_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready=%b, required 1", victim_ready_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        request(6'd3, 8'hFF, 8'h00);
        checks++;
        if (victim_valid_o !== 1'b1 || victim_way_o !== 3'd0 || victim_oh_o !== 8'h01) begin
            errors++;
            $display("FAIL basic_fresh: valid=%b way=%0d oh=%h, required 1 0 01",
                     victim_valid_o, victim_way_o, victim_oh_o);
        end
        tick();
        checks++;
        if (victim_valid_o !== 1'b0 || victim_oh_o !== 8'h01) begin
            errors++;
            $display("FAIL basic_hold: valid=%b oh=%h, required 0 01", victim_valid_o, victim_oh_o);
        end
        $display("test_basic: way=%0d", victim_way_o);
    endtask

    task automatic test_touch_order();
        for (int w = 0; w < 8; w++) touch(6'd3, 3'(w));
        request(6'd3, 8'hFF, 8'h00);
        checks++;
        if (victim_valid_o !== 1'b1 || victim_way_o !== 3'd0 || victim_oh_o !== 8'h01) begin
            errors++;
            $display("FAIL touch_order_lru: way=%0d oh=%h, required 0 01", victim_way_o, victim_oh_o);
        end
        touch(6'd3, 3'd0);
        request(6'd3, 8'hFF, 8'h00);
        checks++;
        if (victim_way_o !== 3'd4 || victim_oh_o !== 8'h10) begin
            errors++;
            $display("FAIL touch_then_zero: way=%0d oh=%h, required 4 10", victim_way_o, victim_oh_o);
        end
        request(6'd5, 8'hFF, 8'h00);
        checks++;
        if (victim_way_o !== 3'd0) begin
            errors++;
            $display("FAIL other_set_untouched: way=%0d, required 0", victim_way_o);
        end
        $display("test_touch_order done");
    endtask

    task automatic test_invalid_first();
        request(6'd3, 8'b1111_0111, 8'h00);
        checks++;
        if (victim_way_o !== 3'd3 || victim_oh_o !== 8'h08 || victim_none_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_first: way=%0d oh=%h none=%b, required 3 08 0",
                     victim_way_o, victim_oh_o, victim_none_o);
        end
        request(6'd3, 8'b1111_0111, 8'h08);
        checks++;
        if (victim_way_o !== 3'd4 || victim_oh_o !== 8'h10) begin
            errors++;
            $display("FAIL invalid_but_locked: way=%0d oh=%h, required 4 10", victim_way_o, victim_oh_o);
        end
        request(6'd3, 8'b0101_1111, 8'h00);
        checks++;
        if (victim_way_o !== 3'd5) begin
            errors++;
            $display("FAIL lowest_invalid: way=%0d, required 5", victim_way_o);
        end
        $display("test_invalid_first done");
    endtask

    task automatic test_locks();
        request(6'd10, 8'hFF, 8'h0F);
        checks++;
        if (victim_way_o !== 3'd4 || victim_oh_o !== 8'h10 || victim_none_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_lower_half: way=%0d oh=%h none=%b, required 4 10 0",
                     victim_way_o, victim_oh_o, victim_none_o);
        end
        request(6'd10, 8'hFF, 8'hFF);
        checks++;
        if (victim_valid_o !== 1'b1 || victim_none_o !== 1'b1 || victim_oh_o !== 8'h00 ||
            victim_way_o !== 3'd0) begin
            errors++;
            $display("FAIL lock_all: none=%b oh=%h way=%0d, required 1 00 0",
                     victim_none_o, victim_oh_o, victim_way_o);
        end
        request(6'd10, 8'hFF, 8'b0111_1111);
        checks++;
        if (victim_way_o !== 3'd7 || victim_none_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_all_but_7: way=%0d none=%b, required 7 0", victim_way_o, victim_none_o);
        end
        $display("test_locks done");
    endtask

    task automatic test_back_to_back();
        victim_req_i = 1'b1; victim_set_i = 6'd3; way_valid_i = 8'hFF; way_lock_i = 8'h00;
        tick();
        checks++;
        if (victim_valid_o !== 1'b1 || victim_way_o !== 3'd4) begin
            errors++;
            $display("FAIL b2b_first: valid=%b way=%0d, required 1 4", victim_valid_o, victim_way_o);
        end
        victim_set_i = 6'd10;
        tick();
        checks++;
        if (victim_valid_o !== 1'b1 || victim_way_o !== 3'd0) begin
            errors++;
            $display("FAIL b2b_second: valid=%b way=%0d, required 1 0", victim_valid_o, victim_way_o);
        end
        victim_req_i = 1'b0;
        tick();
        checks++;
        if (victim_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop: valid=%b, required 0", victim_valid_o);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_diff_sets();
        touch_valid_i = 1'b1; touch_set_i = 6'd20; touch_way_i = 3'd0;
        victim_req_i = 1'b1; victim_set_i = 6'd21;
        tick();
        touch_valid_i = 1'b0; victim_req_i = 1'b0;
        checks++;
        if (victim_way_o !== 3'd0) begin
            errors++;
            $display("FAIL diff_set_req: way=%0d, required 0", victim_way_o);
        end
        request(6'd20, 8'hFF, 8'h00);
        checks++;
        if (victim_way_o !== 3'd4) begin
            errors++;
            $display("FAIL diff_set_touch: way=%0d, required 4", victim_way_o);
        end
        $display("test_diff_sets done");
    endtask

    task automatic test_bypass();
        logic [2:0] exp_way;
`ifdef PLRU_TOUCH_BYPASS_EN
        exp_way = 3'd4;
`else
        exp_way = 3'd0;
`endif
        touch_valid_i = 1'b1; touch_set_i = 6'd30; touch_way_i = 3'd0;
        victim_req_i = 1'b1; victim_set_i = 6'd30; way_valid_i = 8'hFF; way_lock_i = 8'h00;
        tick();
        touch_valid_i = 1'b0; victim_req_i = 1'b0;
        checks++;
        if (victim_way_o !== exp_way) begin
            errors++;
            $display("FAIL same_cycle_touch: way=%0d, required %0d", victim_way_o, exp_way);
        end
        request(6'd30, 8'hFF, 8'h00);
        checks++;
        if (victim_way_o !== 3'd4) begin
            errors++;
            $display("FAIL touch_committed: way=%0d, required 4", victim_way_o);
        end
        $display("test_bypass done");
    endtask

    task automatic test_flush();
        int n;
        flush_i = 1'b1; victim_req_i = 1'b1; victim_set_i = 6'd3;
        #1;
        checks++;
        if (victim_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_wins_ready: ready=%b, required 0", victim_ready_o);
        end
        tick();
        flush_i = 1'b0; victim_req_i = 1'b0;
        checks++;
        if (victim_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_start: valid=%b busy=%b, required 0 1", victim_valid_o, busy_o);
        end
        n = 0;
        while (busy_o === 1'b1 && n < 200) begin
            if (victim_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_ready_low: cycle %0d ready=%b, required 0", n, victim_ready_o);
            end
            victim_req_i  = (n == 5);
            flush_i       = (n == 10);
            touch_valid_i = (n == 62);
            touch_set_i   = 6'd3; touch_way_i = 3'd0;
            n++;
            tick();
            victim_req_i = 1'b0; flush_i = 1'b0; touch_valid_i = 1'b0;
            if (n == 6 && victim_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_req_accepted: valid=%b, required 0", victim_valid_o);
            end
        end
        checks++;
        if (n != NUM_SETS) begin
            errors++;
            $display("FAIL flush_length: busy cycles=%0d, required %0d", n, NUM_SETS);
        end
        for (int s = 0; s < 64; s += 7) begin
            request(6'(s), 8'hFF, 8'h00);
            checks++;
            if (victim_valid_o !== 1'b1 || victim_way_o !== 3'd0) begin
                errors++;
                $display("FAIL post_flush_set%0d: valid=%b way=%0d, required 1 0",
                         s, victim_valid_o, victim_way_o);
            end
        end
        $display("test_flush: busy cycles=%0d", n);
    endtask

    task automatic test_reset_mid_sweep();
        touch(6'd40, 3'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst_ni = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || victim_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_sweep: busy=%b ready=%b, required 0 1", busy_o, victim_ready_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        request(6'd40, 8'hFF, 8'h00);
        checks++;
        if (victim_way_o !== 3'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_tree: way=%0d busy=%b, required 0 0", victim_way_o, busy_o);
        end
        $display("test_reset_mid_sweep done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_touch_order();
        test_invalid_first();
        test_locks();
        test_back_to_back();
        test_diff_sets();
        test_bypass();
        test_flush();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
